// File: rtl/countdown_counter.sv
// Loadable down-counter with IDLE/RUN control, a one-cycle done pulse at terminal
// count, and optional auto-reload of the last loaded value for periodic loops.
module countdown_counter #(
    parameter int unsigned BITWIDTH = 10
) (
    input  logic                CDOWN_Clk,
    input  logic                CDOWN_Clr,
    input  logic                CDOWN_Load,
    input  logic [BITWIDTH-1:0] CDOWN_Number,
    input  logic                CDOWN_En,
    input  logic                CDOWN_AutoReload,
    output logic [BITWIDTH-1:0] CDOWN_Out,
    output logic                CDOWN_Zero_Flag,
    output logic                CDOWN_Busy,
    output logic                CDOWN_Done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [BITWIDTH-1:0] cnt_q, cnt_d;
    logic [BITWIDTH-1:0] reload_q, reload_d;
    logic                done_q, done_d;

    always_ff @(posedge CDOWN_Clk or negedge CDOWN_Clr) begin
        if (!CDOWN_Clr) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            reload_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            reload_q <= reload_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        reload_d = reload_q;
        done_d   = 1'b0;
        if (CDOWN_Load) begin
            cnt_d    = CDOWN_Number;
            reload_d = CDOWN_Number;
            if (CDOWN_Number != '0) begin
                state_d = RUN;
            end else begin
                // Zero-length loop: finish at once without entering RUN.
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end else if (state_q == RUN && CDOWN_En) begin
            if (cnt_q > BITWIDTH'(1)) begin
                cnt_d = cnt_q - BITWIDTH'(1);
            end else begin
                // Terminal edge; a count of 0 cannot occur in RUN, treat it as terminal too.
                done_d = 1'b1;
                if (CDOWN_AutoReload) begin
                    cnt_d = reload_q;
                end else begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
        end
    end

    assign CDOWN_Out       = cnt_q;
    assign CDOWN_Zero_Flag = (cnt_q == '0);
    assign CDOWN_Busy      = (state_q == RUN);
    assign CDOWN_Done      = done_q;

endmodule

// File: doc/countdown_counter.md
Name: countdown_counter

Overview:
Loadable down-counter with a run/done handshake, complementing the free-running up counter in the accelerator's loop-control logic. A controller loads a start value. The block decrements on each enabled clock and emits a single-cycle done pulse at terminal count. Optional auto-reload gives a periodic done pulse for repeating window/stride loops. It sits beside the CNN datapath sequencers as the terminal-count source for feature-map, kernel and channel loops.

Parameters:
BITWIDTH, 10, width of the count and the load value.

Ports:
CDOWN_Clk  input  1  clock, positive edge.
CDOWN_Clr  input  1  reset, asynchronous, active-low.
CDOWN_Load  input  1  load CDOWN_Number and arm the counter.
CDOWN_Number  input  BITWIDTH  start/reload value, sampled only when CDOWN_Load=1.
CDOWN_En  input  1  decrement enable while running.
CDOWN_AutoReload  input  1  at terminal count, reload stored value instead of stopping.
CDOWN_Out  output  BITWIDTH  current count, registered.
CDOWN_Zero_Flag  output  1  combinational, CDOWN_Out==0.
CDOWN_Busy  output  1  registered, 1 while in RUN.
CDOWN_Done  output  1  registered, one-cycle pulse at terminal count.

Behaviour:
- One clock (CDOWN_Clk). Reset is asynchronous and active-low (CDOWN_Clr).
- Reset values: counter=0, reload register=0, state=IDLE, CDOWN_Busy=0, CDOWN_Done=0. Therefore CDOWN_Zero_Flag=1.
- States: IDLE and RUN. CDOWN_Busy is 1 exactly when state=RUN.
- Priority at each rising edge: reset, then Load, then decrement.
- CDOWN_Done defaults to 0 every cycle. It is 1 only in the cycle immediately following the edge that produced terminal count.
- Load=1 with Number!=0, from any state:
  - counter<=Number; reload<=Number; state<=RUN.
  - Done<=0, including when the same edge would otherwise have been terminal.
- Load=1 with Number==0:
  - counter<=0; reload<=0; state<=IDLE; Done<=1. A zero-length loop completes immediately.
- RUN, En=1, counter>1: counter<=counter-1.
- RUN, En=1, counter==1, AutoReload=0: counter<=0; state<=IDLE; Done<=1.
- RUN, En=1, counter==1, AutoReload=1: counter<=reload; state stays RUN; Done<=1. The period is reload enabled cycles; 0 is never shown.
- RUN, En=0: counter and state hold; Done=0.
- IDLE: En is ignored. The counter holds and never wraps below 0.
- AutoReload is sampled only at the terminal edge. Changing it mid-count has no other effect.
- Arithmetic is unsigned BITWIDTH. The maximum load value 2^BITWIDTH-1 counts that many enabled cycles.
- Latency:
  - CDOWN_Out reflects Load one cycle after the load edge.
  - Done is asserted in the same cycle CDOWN_Out first shows the terminal value (0, or reload when auto-reloading).
- Reset asserted mid-RUN forces the reset values immediately, without a clock edge. A Done pulse in flight is cleared.

Test Plan:
- Reset: hold CDOWN_Clr=0 -> Out=0, Zero_Flag=1, Busy=0, Done=0. Release, En=1, no Load -> Out stays 0, Done stays 0.
- Load Number=5 with En=1 continuously:
  - Out reads 5,4,3,2,1,0 on consecutive cycles.
  - Done=1 only in the Out=0 cycle. Busy drops in that same cycle.
- Load 3 with En pattern 1,0,1,0,1 -> Out 3,2,2,1,1,0. Done pulses once, after the 3rd enabled cycle.
- AutoReload=1, Load 3, En=1 for 9 cycles -> Out 3,2,1,3,2,1,3,2,1. Done pulses in each cycle that Out returns to 3 from 1. Busy stays 1 throughout.
- Load and Zero conditions:
  - Load 8, decrement twice, then Load 2 -> Out 2,1,0 with exactly one Done.
  - Load asserted on the terminal edge -> no Done; counter shows the new value.
  - Load Number=0 -> Done pulse next cycle, Busy=0.
- Reset mid-count: Load 1023, after 100 cycles drop CDOWN_Clr between edges -> Out=0 and Busy=0 immediately. With BITWIDTH=10 and Load 1023, Done pulses exactly 1023 enabled cycles after load.
